// File: rtl/ysyx_24100006_rd_arbiter_if.sv
// Read-address/read-data bundle for one side of the read arbiter.
// The master modport is the side that issues reads; slave is the side that serves them.
interface ysyx_24100006_rd_arbiter_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/ysyx_24100006_rd_arbiter.sv
// Two-requester (IFU=m0, LSU=m1) read arbiter onto one shared slave, one transaction in flight.
// Define ROUND_ROBIN_EN for alternating grants on contention; otherwise the LSU always wins.
module ysyx_24100006_rd_arbiter (
    input  logic                            clk,
    input  logic                            reset,
    ysyx_24100006_rd_arbiter_if.slave       m0,
    ysyx_24100006_rd_arbiter_if.slave       m1,
    ysyx_24100006_rd_arbiter_if.master      s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic        grant_r;
    logic        grant_s;
    logic        win_s;
    logic        rready_s;
`ifdef ROUND_ROBIN_EN
    logic        last_r;
    logic        last_s;
`endif

    // Pick the requester that wins arbitration this cycle (1 = m1).
    always_comb begin
        win_s = 1'b0;
        if (m0.arvalid && m1.arvalid) begin
`ifdef ROUND_ROBIN_EN
            win_s = ~last_r;
`else
            win_s = 1'b1;
`endif
        end else if (m1.arvalid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state logic and all channel outputs.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        grant_s    = grant_r;
`ifdef ROUND_ROBIN_EN
        last_s     = last_r;
`endif
        rready_s   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        s.arvalid  = 1'b0;
        s.araddr   = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (m0.arvalid || m1.arvalid) begin
                    m0.arready = ~win_s;
                    m1.arready = win_s;
                    addr_s     = win_s ? m1.araddr : m0.araddr;
                    grant_s    = win_s;
                    state_s    = ST_ADDR;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_ADDR: begin
                s.arvalid = 1'b1;
                if (s.arready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                // Only rvalid is steered; the data/resp/last buses fan out to both requesters.
                rready_s  = grant_r ? m1.rready : m0.rready;
                m0.rvalid = s.rvalid & ~grant_r;
                m1.rvalid = s.rvalid & grant_r;
                if (s.rvalid && rready_s && s.rlast) begin
                    state_s = ST_IDLE;
`ifdef ROUND_ROBIN_EN
                    last_s  = grant_r;
`endif
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign s.rready  = rready_s;
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;
    assign m0.rresp  = s.rresp;
    assign m1.rresp  = s.rresp;
    assign m0.rlast  = s.rlast;
    assign m1.rlast  = s.rlast;

    // State and transaction registers; last served starts at m1 so m0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            addr_r  <= 32'h0000_0000;
            grant_r <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_r  <= 1'b1;
`endif
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            grant_r <= grant_s;
`ifdef ROUND_ROBIN_EN
            last_r  <= last_s;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_rd_arbiter.sv
// Self-checking bench for the read arbiter: randomized transactions against a transaction-level model.
module tb_ysyx_24100006_rd_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   last_served;

    ysyx_24100006_rd_arbiter_if m0_if ();
    ysyx_24100006_rd_arbiter_if m1_if ();
    ysyx_24100006_rd_arbiter_if s_if ();

    ysyx_24100006_rd_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner the specification dictates for the given request pattern.
    function automatic int model_winner(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ROUND_ROBIN_EN
            return (last_served == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    task automatic clear_inputs();
        m0_if.araddr = 32'h0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
        m1_if.araddr = 32'h0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0;
        s_if.rresp = 2'b00; s_if.rlast = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        last_served = 1;
    endtask

    // One full transaction from IDLE back to IDLE; returns the granted requester.
    task automatic do_txn(input bit v0, input bit v1, input bit hold, input int ar_wait,
                          input int r_wait, input int nbeats, output int granted);
        logic [31:0] a0, a1, exp_addr, data;
        logic [1:0]  resp;
        logic [5:0]  obs, exp;
        int          w;
        a0 = $urandom; a1 = $urandom;
        m0_if.araddr = a0; m0_if.arvalid = v0;
        m1_if.araddr = a1; m1_if.arvalid = v1;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0;
        w = model_winner(v0, v1);
        granted = w;
        exp_addr = (w == 1) ? a1 : a0;
        @(negedge clk);
        tests++;
        obs = {m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready, m0_if.rvalid, m1_if.rvalid};
        exp = {(w == 0), (w == 1), 4'b0000};
        if (obs !== exp) begin
            fails++;
            $display("FAIL idle_grant: got %b expected %b", obs, exp);
        end
        step();
        m0_if.araddr = $urandom; m1_if.araddr = $urandom;
        if (!hold) begin
            m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
        end
        for (int i = 0; i <= ar_wait; i++) begin
            s_if.arready = (i == ar_wait);
            @(negedge clk);
            tests++;
            obs = {m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready, m0_if.rvalid, m1_if.rvalid};
            if (obs !== 6'b001000 || s_if.araddr !== exp_addr) begin
                fails++;
                $display("FAIL addr_phase cyc %0d: got %b addr %h expected 001000 addr %h",
                         i, obs, s_if.araddr, exp_addr);
            end
            step();
        end
        s_if.arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            data = $urandom; resp = 2'($urandom_range(0, 3));
            s_if.rvalid = 1'b1; s_if.rdata = data; s_if.rresp = resp;
            s_if.rlast = (b == nbeats - 1);
            for (int i = 0; i <= r_wait; i++) begin
                if (w == 1) begin
                    m1_if.rready = (i == r_wait); m0_if.rready = 1'($urandom);
                end else begin
                    m0_if.rready = (i == r_wait); m1_if.rready = 1'($urandom);
                end
                @(negedge clk);
                tests++;
                obs = {m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready, m0_if.rvalid, m1_if.rvalid};
                exp = {3'b000, (i == r_wait), (w == 0), (w == 1)};
                if (obs !== exp || m0_if.rdata !== data || m1_if.rdata !== data ||
                    m0_if.rresp !== resp || m1_if.rresp !== resp ||
                    m0_if.rlast !== s_if.rlast || m1_if.rlast !== s_if.rlast) begin
                    fails++;
                    $display("FAIL data_phase beat %0d cyc %0d: got %b rdata %h/%h expected %b rdata %h",
                             b, i, obs, m0_if.rdata, m1_if.rdata, exp, data);
                end
                step();
            end
        end
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        m0_if.rready = 1'b0; m1_if.rready = 1'b0;
        last_served = w;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        do_reset();
        @(negedge clk);
        tests++;
        obs = {m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready, m0_if.rvalid, m1_if.rvalid};
        if (obs !== 6'b000000 || s_if.araddr !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b addr %h expected 000000 addr 0", obs, s_if.araddr);
        end
        step();
        @(negedge clk);
        tests++;
        if (s_if.arvalid !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: s_arvalid %b expected 0", s_if.arvalid);
        end
        step();
    endtask

    task automatic test_basic();
        logic [5:0] obs;
        do_reset();
        m0_if.araddr = 32'h0200_0000; m0_if.arvalid = 1'b1;
        @(negedge clk);
        tests++;
        if (m0_if.arready !== 1'b1 || m1_if.arready !== 1'b0) begin
            fails++;
            $display("FAIL basic_arready: got %b%b expected 10", m0_if.arready, m1_if.arready);
        end
        step();
        m0_if.arvalid = 1'b0; s_if.arready = 1'b1;
        @(negedge clk);
        tests++;
        if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h0200_0000) begin
            fails++;
            $display("FAIL basic_addr: got %b %h expected 1 02000000", s_if.arvalid, s_if.araddr);
        end
        step();
        s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rdata = 32'h1234_5678;
        s_if.rlast = 1'b1; m0_if.rready = 1'b1;
        @(negedge clk);
        tests++;
        if (m0_if.rvalid !== 1'b1 || m1_if.rvalid !== 1'b0 || m0_if.rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_data: got rvalid %b%b rdata %h expected 10 12345678",
                     m0_if.rvalid, m1_if.rvalid, m0_if.rdata);
        end
        step();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0; m0_if.rready = 1'b0;
        @(negedge clk);
        tests++;
        obs = {m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready, m0_if.rvalid, m1_if.rvalid};
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL basic_back_idle: got %b expected 000000", obs);
        end
        step();
        last_served = 0;
    endtask

    task automatic test_contention();
        int g;
        int exp_g;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_txn(1'b1, 1'b1, 1'b1, 0, 0, 1, g);
`ifdef ROUND_ROBIN_EN
            exp_g = k % 2;
`else
            exp_g = 1;
`endif
            // g is the model's pick; the grant the DUT made was compared inside do_txn
            tests++;
            if (g !== exp_g) begin
                fails++;
                $display("FAIL contention_seq %0d: got %0d expected %0d", k, g, exp_g);
            end
        end
        clear_inputs();
    endtask

    task automatic test_stalls();
        int g;
        do_txn(1'b1, 1'b0, 1'b0, 5, 0, 1, g);
        do_txn(1'b0, 1'b1, 1'b0, 0, 3, 1, g);
        do_txn(1'b1, 1'b0, 1'b1, 2, 2, 3, g);
        clear_inputs();
    endtask

    task automatic test_random();
        int g;
        int r;
        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(1, 3);
            do_txn(r[0], r[1], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(1, 4), g);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        do_reset();
        m1_if.araddr = 32'hCAFE_0000; m1_if.arvalid = 1'b1;
        step();
        m1_if.arvalid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (s_if.arvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_addr: s_arvalid %b expected 0", s_if.arvalid);
        end
        step();
        m1_if.arvalid = 1'b1;
        step();
        m1_if.arvalid = 1'b0; s_if.arready = 1'b1;
        step();
        s_if.arready = 1'b0; s_if.rvalid = 1'b1; s_if.rlast = 1'b0; m1_if.rready = 1'b1;
        @(negedge clk);
        tests++;
        if (m1_if.rvalid !== 1'b1 || s_if.rready !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_data: got rvalid %b rready %b expected 1 1",
                     m1_if.rvalid, s_if.rready);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m1_if.rready = 1'b0;
        @(negedge clk);
        tests++;
        obs = {m0_if.arready, m1_if.arready, s_if.arvalid, s_if.rready, m0_if.rvalid, m1_if.rvalid};
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL reset_in_data: got %b expected 000000", obs);
        end
        step();
        clear_inputs();
        last_served = 1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_served = 1;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_contention();
        test_stalls();
        test_random();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
